// File: rtl/instr_issue_pkg.sv
// Shared definitions for the issue unit and control decoder: opcodes, fields, FSM states.
// No logic and no latency.
// No flow control.
package instr_issue_pkg;

    localparam logic [3:0] OP_LW    = 4'b0000;
    localparam logic [3:0] OP_SW    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MOV   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_JMPZ  = 4'b0101;
    localparam logic [3:0] OP_STOP  = 4'b0111;
    localparam logic [3:0] OP_ADDF  = 4'b1000;
    localparam logic [3:0] OP_MULTF = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 0;

    localparam logic [15:0] NOP_INSTR = 16'hF000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_BUBBLE,
        ST_HALT
    } state_e;

    function automatic logic op_known(input logic [3:0] op);
        case (op)
            OP_LW, OP_SW, OP_ADD, OP_MOV, OP_SUB, OP_JMPZ,
            OP_STOP, OP_ADDF, OP_MULTF, OP_NOP: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Unknown opcodes become NOP so downstream never sees an undecodable op.
    function automatic logic [15:0] canon_instr(input logic [15:0] instr);
        return op_known(instr[OP_MSB:OP_LSB]) ? instr : {OP_NOP, instr[RD_MSB:RT_LSB]};
    endfunction

endpackage

// File: rtl/instr_issue_load_use_detect.sv
// Flags a fetched instruction that reads the register of a just-issued LW.
// Combinational, zero latency.
// No flow control.
module load_use_detect
    import instr_issue_pkg::*;
(
    input  logic [15:0] instr_i,
    input  logic        lw_pending_i,
    input  logic [3:0]  lw_rd_i,
    output logic        hazard_o
);

    logic [3:0] op;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       unused_rd_bits;

    assign op             = instr_i[OP_MSB:OP_LSB];
    assign rs             = instr_i[RS_MSB:RS_LSB];
    assign rt             = instr_i[RT_MSB:RT_LSB];
    assign unused_rd_bits = ^instr_i[RD_MSB:RD_LSB];

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADDF, OP_MULTF, OP_SW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_LW, OP_JMPZ: use_rs = 1'b1;
            default: ;
        endcase
    end

    assign hazard_o = lw_pending_i &&
                      ((use_rs && (rs == lw_rd_i)) || (use_rt && (rt == lw_rd_i)));

endmodule

// File: rtl/instr_issue.sv
// Fetch/issue FSM feeding the ID stage; inserts load-use bubbles, follows redirects, halts on STOP.
// Issue valid one cycle after imem_valid_i; all outputs registered.
// Holds issue outputs stable while id_ready_i is low; one fetch outstanding at most.
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_instr_i,
    output logic                   issue_valid_o,
    input  logic                   id_ready_i,
    output logic [INSTR_WIDTH-1:0] issue_instr_o,
    output logic [PC_WIDTH-1:0]    issue_pc_o,
    output logic [3:0]             opcode_o,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   halted_o
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    buf_pc_q, buf_pc_d;
    logic [INSTR_WIDTH-1:0] buf_q, buf_d;
    logic                   lw_pending_q, lw_pending_d;
    logic [3:0]             lw_rd_q, lw_rd_d;

    logic                   imem_req_q, imem_req_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [INSTR_WIDTH-1:0] issue_instr_q, issue_instr_d;
    logic [PC_WIDTH-1:0]    issue_pc_q, issue_pc_d;
    logic [3:0]             opcode_q, opcode_d;
    logic                   halted_q, halted_d;

    logic                   hazard;

    load_use_detect u_load_use_detect (
        .instr_i      (imem_instr_i),
        .lw_pending_i (lw_pending_q),
        .lw_rd_i      (lw_rd_q),
        .hazard_o     (hazard)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_pc_d     = buf_pc_q;
        buf_d        = buf_q;
        lw_pending_d = lw_pending_q;
        lw_rd_d      = lw_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                end
            end
            ST_FETCH: begin
                if (!redirect_i && imem_valid_i) begin
                    buf_d    = canon_instr(imem_instr_i);
                    buf_pc_d = pc_q;
                    pc_d     = pc_q + PC_ONE;
                    state_d  = hazard ? ST_BUBBLE : ST_ISSUE;
                end
            end
            ST_BUBBLE: begin
                if (!redirect_i && id_ready_i) begin
                    lw_pending_d = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!redirect_i && id_ready_i) begin
                    lw_pending_d = (buf_q[OP_MSB:OP_LSB] == OP_LW);
                    lw_rd_d      = buf_q[RD_MSB:RD_LSB];
                    state_d      = (buf_q[OP_MSB:OP_LSB] == OP_STOP) ? ST_HALT : ST_FETCH;
                end
            end
            default: ;
        endcase

        // Redirect overrides everything in the active states; a same-cycle
        // handshake has already been consumed by ID, so nothing is replayed.
        if (redirect_i && (state_q == ST_FETCH || state_q == ST_ISSUE || state_q == ST_BUBBLE)) begin
            pc_d         = redirect_pc_i;
            buf_d        = NOP_INSTR;
            lw_pending_d = 1'b0;
            state_d      = ST_FETCH;
        end

        imem_req_d    = (state_d == ST_FETCH);
        issue_valid_d = (state_d == ST_ISSUE) || (state_d == ST_BUBBLE);
        issue_instr_d = (state_d == ST_BUBBLE) ? NOP_INSTR : buf_d;
        issue_pc_d    = buf_pc_d;
        opcode_d      = issue_valid_d ? issue_instr_d[OP_MSB:OP_LSB] : OP_NOP;
        halted_d      = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            buf_pc_q      <= '0;
            buf_q         <= NOP_INSTR;
            lw_pending_q  <= 1'b0;
            lw_rd_q       <= '0;
            imem_req_q    <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= NOP_INSTR;
            issue_pc_q    <= '0;
            opcode_q      <= OP_NOP;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_pc_q      <= buf_pc_d;
            buf_q         <= buf_d;
            lw_pending_q  <= lw_pending_d;
            lw_rd_q       <= lw_rd_d;
            imem_req_q    <= imem_req_d;
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            issue_pc_q    <= issue_pc_d;
            opcode_q      <= opcode_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = pc_q;
    assign issue_valid_o = issue_valid_q;
    assign issue_instr_o = issue_instr_q;
    assign issue_pc_o    = issue_pc_q;
    assign opcode_o      = opcode_q;
    assign halted_o      = halted_q;

endmodule
